// File: rtl/mem_arbiter.sv
// Two-requester (core / debug) arbiter for one shared single-port memory, bounded-burst fairness.
// Grant and memory mux are combinational; read data returns registered one cycle after the grant.
module mem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_rvalid,
    output logic [DATA_W-1:0] c_rdata,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,

    output logic              core_stall,

    output logic [ADDR_W-1:0] m_addr,
    output logic              m_wr_en,
    output logic [DATA_W-1:0] m_wr_data,
    input  logic [DATA_W-1:0] m_rd_data
);

    localparam int                CNT_W   = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, OWN_C, OWN_D} owner_t;
    typedef enum logic       {LAST_C, LAST_D}      last_t;

    owner_t            r_owner;
    logic [CNT_W-1:0]  r_cnt;
    last_t             r_last;
    logic              r_c_rvalid;
    logic              r_d_rvalid;
    logic [DATA_W-1:0] r_c_rdata;
    logic [DATA_W-1:0] r_d_rdata;

    logic w_c_win;
    logic w_d_win;

    // A lone requester always wins; on a tie the owner keeps the port until its burst is spent.
    always_comb begin
        w_c_win = 1'b0;
        w_d_win = 1'b0;
        if (!reset) begin
            if (c_req && !d_req) begin
                w_c_win = 1'b1;
            end else if (d_req && !c_req) begin
                w_d_win = 1'b1;
            end else if (c_req && d_req) begin
                case (r_owner)
                    OWN_C: begin
                        if (r_cnt < CNT_MAX) w_c_win = 1'b1;
                        else                 w_d_win = 1'b1;
                    end
                    OWN_D: begin
                        if (r_cnt < CNT_MAX) w_d_win = 1'b1;
                        else                 w_c_win = 1'b1;
                    end
                    default: begin
                        if (r_last == LAST_D) w_c_win = 1'b1;
                        else                  w_d_win = 1'b1;
                    end
                endcase
            end
        end
    end

    assign c_gnt      = w_c_win;
    assign d_gnt      = w_d_win;
    assign core_stall = c_req & ~w_c_win;

    assign m_addr    = w_c_win ? c_addr  : (w_d_win ? d_addr  : '0);
    assign m_wr_data = w_c_win ? c_wdata : (w_d_win ? d_wdata : '0);
    assign m_wr_en   = (w_c_win & c_we) | (w_d_win & d_we);

    assign c_rvalid = r_c_rvalid;
    assign d_rvalid = r_d_rvalid;
    assign c_rdata  = r_c_rdata;
    assign d_rdata  = r_d_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_owner    <= IDLE;
            r_cnt      <= '0;
            r_last     <= LAST_D;
            r_c_rvalid <= 1'b0;
            r_d_rvalid <= 1'b0;
            r_c_rdata  <= '0;
            r_d_rdata  <= '0;
        end else begin
            r_c_rvalid <= w_c_win & ~c_we;
            r_d_rvalid <= w_d_win & ~d_we;
            if (w_c_win && !c_we) r_c_rdata <= m_rd_data;
            if (w_d_win && !d_we) r_d_rdata <= m_rd_data;

            // Burst count saturates so a long solo run still yields immediately on a tie.
            if (w_c_win) begin
                r_owner <= OWN_C;
                r_last  <= LAST_C;
                if (r_owner == OWN_C) r_cnt <= (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_ONE;
                else                  r_cnt <= CNT_ONE;
            end else if (w_d_win) begin
                r_owner <= OWN_D;
                r_last  <= LAST_D;
                if (r_owner == OWN_D) r_cnt <= (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_ONE;
                else                  r_cnt <= CNT_ONE;
            end else begin
                r_owner <= IDLE;
                r_cnt   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios then constrained-random traffic against a streak-based model.
module tb_mem_arbiter;

    localparam int MAXB = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        c_req, c_we, d_req, d_we;
    logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
    logic        c_gnt, c_rvalid, d_gnt, d_rvalid, core_stall, m_wr_en;
    logic [31:0] c_rdata, d_rdata, m_addr, m_wr_data, m_rd_data;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(MAXB)) dut (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .core_stall(core_stall),
        .m_addr(m_addr), .m_wr_en(m_wr_en), .m_wr_data(m_wr_data), .m_rd_data(m_rd_data)
    );

    function automatic logic [31:0] memval(input int i);
        logic [7:0] b;
        b = i[7:0];
        return (i == 16) ? 32'hDEADBEEF : {b, ~b, b ^ 8'h5A, 8'hC3};
    endfunction

    // Memory: combinational read, write at posedge; self-initialises on the first edge.
    logic [31:0] mem [256];
    logic        mem_ready = 1'b0;
    assign m_rd_data = mem[m_addr[7:0]];
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) mem[i] <= memval(i);
            mem_ready <= 1'b1;
        end else if (m_wr_en) begin
            mem[m_addr[7:0]] <= m_wr_data;
        end
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    endtask

    // Reference model: who held the port last cycle (0 none, 1 core, 2 debug), length of
    // the unbroken run of grants to that requester, and who won most recently.
    logic [31:0] ref_mem [256];
    int          prev_gnt, run, last_win;
    logic        m_init = 1'b0;
    logic        exp_cv, exp_dv;
    logic [31:0] exp_cd, exp_dd;

    function automatic int model_grant(input logic rst, input logic cr, input logic dr);
        if (rst)             return 0;
        if (cr && !dr)       return 1;
        if (dr && !cr)       return 2;
        if (!cr && !dr)      return 0;
        if (prev_gnt == 0)   return (last_win == 1) ? 2 : 1;
        if (run < MAXB)      return prev_gnt;
        return 3 - prev_gnt;
    endfunction

    task automatic cycle(input logic rst,
                         input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                         input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd,
                         output logic og_c, output logic og_d);
        int g;
        logic ewe;
        logic [31:0] ea, ed;
        reset = rst;
        c_req = cr; c_we = cw; c_addr = ca; c_wdata = cd;
        d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;
        @(negedge clk);
        if (m_init) begin
            check("c_rvalid", {63'd0, c_rvalid}, {63'd0, exp_cv});
            check("c_rdata",  {32'd0, c_rdata},  {32'd0, exp_cd});
            check("d_rvalid", {63'd0, d_rvalid}, {63'd0, exp_dv});
            check("d_rdata",  {32'd0, d_rdata},  {32'd0, exp_dd});
        end
        g   = model_grant(rst, cr, dr);
        ewe = (g == 1) ? cw : ((g == 2) ? dw : 1'b0);
        ea  = (g == 1) ? ca : ((g == 2) ? da : 32'd0);
        ed  = (g == 1) ? cd : ((g == 2) ? dd : 32'd0);
        check("c_gnt",      {63'd0, c_gnt},      {63'd0, g == 1});
        check("d_gnt",      {63'd0, d_gnt},      {63'd0, g == 2});
        check("core_stall", {63'd0, core_stall}, {63'd0, cr && g != 1});
        check("m_wr_en",    {63'd0, m_wr_en},    {63'd0, ewe});
        check("m_addr",     {32'd0, m_addr},     {32'd0, ea});
        check("m_wr_data",  {32'd0, m_wr_data},  {32'd0, ed});
        check("gnt_excl",   {63'd0, c_gnt & d_gnt}, 64'd0);
        og_c = c_gnt;
        og_d = d_gnt;
        if (rst) begin
            prev_gnt = 0; run = 0; last_win = 2;
            exp_cv = 1'b0; exp_dv = 1'b0; exp_cd = '0; exp_dd = '0;
            m_init = 1'b1;
        end else begin
            exp_cv = (g == 1) && !cw;
            exp_dv = (g == 2) && !dw;
            if (exp_cv) exp_cd = ref_mem[ca[7:0]];
            if (exp_dv) exp_dd = ref_mem[da[7:0]];
            if (ewe) ref_mem[ea[7:0]] = ed;
            if (g == 0) begin
                prev_gnt = 0; run = 0;
            end else begin
                run = (g == prev_gnt) ? ((run < MAXB) ? run + 1 : MAXB) : 1;
                prev_gnt = g;
                last_win = g;
            end
        end
        @(posedge clk);
        #1;
    endtask

    logic        gc, gd;
    logic        cp, cpw, dp, dpw, rst_r;
    logic [31:0] cpa, cpd, dpa, dpd;

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = memval(i);
        prev_gnt = 0; run = 0; last_win = 2;
        exp_cv = 0; exp_dv = 0; exp_cd = 0; exp_dd = 0;
        reset = 1'b1;
        c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0;
        d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        repeat (2) @(posedge clk);
        #1;
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, gc, gd);
        cycle(1, 1, 0, 0, 0, 1, 0, 0, 0, gc, gd);
        check("rst_gnt", {62'd0, gc, gd}, 64'd0);

        // Core-only read of a known location.
        cycle(0, 1, 0, 32'h10, 0, 0, 0, 0, 0, gc, gd);
        check("rd_gnt", {63'd0, gc}, 64'd1);
        check("rd_rvalid", {63'd0, c_rvalid}, 64'd1);
        check("rd_rdata", {32'd0, c_rdata}, 64'hDEADBEEF);

        // Debug write followed immediately by a core read of the same address.
        cycle(0, 0, 0, 0, 0, 1, 1, 32'h20, 32'h12345678, gc, gd);
        check("dwr_gnt", {63'd0, gd}, 64'd1);
        cycle(0, 1, 0, 32'h20, 0, 0, 0, 0, 0, gc, gd);
        check("raw_rdata", {32'd0, c_rdata}, 64'h12345678);
        check("raw_d_rvalid", {63'd0, d_rvalid}, 64'd0);

        // Two core grants, an idle cycle, then a tie goes to debug.
        cycle(0, 1, 0, 32'h1, 0, 0, 0, 0, 0, gc, gd);
        cycle(0, 1, 0, 32'h2, 0, 0, 0, 0, 0, gc, gd);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, gc, gd);
        cycle(0, 1, 0, 32'h3, 0, 1, 0, 32'h4, 0, gc, gd);
        check("gap_tie_d", {62'd0, gc, gd}, 64'd1);

        // Sustained tie after reset: 4 core, 4 debug, 4 core.
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, gc, gd);
        for (int i = 0; i < 12; i++) begin
            cycle(0, 1, 0, 32'(i), 0, 1, 0, 32'(i + 64), 0, gc, gd);
            check("tie_seq", {62'd0, gc, gd}, ((i / 4) % 2 == 0) ? 64'd2 : 64'd1);
        end

        // Reset landing on a core read grant.
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, gc, gd);
        cycle(0, 1, 0, 32'h10, 0, 1, 0, 32'h30, 0, gc, gd);
        check("pre_rst_gnt", {63'd0, gc}, 64'd1);
        cycle(1, 1, 0, 32'h10, 0, 1, 0, 32'h30, 0, gc, gd);
        check("rst_mid_gnt", {62'd0, gc, gd}, 64'd0);
        check("rst_mid_rvalid", {63'd0, c_rvalid}, 64'd0);
        cycle(0, 1, 0, 32'h10, 0, 1, 0, 32'h30, 0, gc, gd);
        check("post_rst_tie", {62'd0, gc, gd}, 64'd2);

        // Random traffic; each requester holds its transaction until granted.
        cp = 0; dp = 0; cpw = 0; dpw = 0; cpa = 0; cpd = 0; dpa = 0; dpd = 0;
        for (int n = 0; n < 3000; n++) begin
            if (!cp && $urandom_range(0, 3) != 0) begin
                cp = 1; cpw = $urandom_range(0, 2) == 0;
                cpa = {$urandom_range(0, 3) == 0 ? 24'($urandom) : 24'd0, 8'($urandom)};
                cpd = $urandom;
            end
            if (!dp && $urandom_range(0, 2) != 0) begin
                dp = 1; dpw = $urandom_range(0, 1) == 0;
                dpa = {24'd0, 8'($urandom)};
                dpd = $urandom;
            end
            rst_r = $urandom_range(0, 99) == 0;
            cycle(rst_r, cp, cpw, cpa, cpd, dp, dpw, dpa, dpd, gc, gd);
            if (gc) cp = 0;
            if (gd) dp = 0;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
